// File: rtl/mm_bram_host_port.sv
// mm_bram_host_port
// Host-side responder for the Montgomery multiplier's operand/result Block RAM.
// It owns the DEPTH x 32 memory behind the multiplier's BRAM master port and
// sequences one multiplication per round:
//   LOAD  : stream LOAD_WORDS 17-bit limbs from the host into words 0..LOAD_WORDS-1
//   START : one-cycle start pulse to the multiplier
//   WAIT  : wait for the multiplier's done
//   READ  : stream S result limbs from RESULT_BASE onward to the host
//
// Ports
//   clock_i, reset_i        single clock, synchronous active-high reset
//   BRAM_en_i/we_i/addr_i   multiplier-side access: byte address, per-byte write
//   BRAM_din_i/dout_o       enables, read-first, 1-cycle registered read data
//   s_valid_i/ready_o/data_i   host limb sink (valid/ready)
//   m_valid_o/ready_i/data_o   result limb source (valid/ready)
//   mm_start_o, mm_done_i   multiplier control handshake
//   busy_o                  high while in START, WAIT or READ
module mm_bram_host_port #(
   parameter int WIDTH       = 256,
   parameter int LOAD_WORDS  = 3 * (((WIDTH + 1) / 17) + 1) + 1,
   parameter int RESULT_BASE = 3 * (((WIDTH + 1) / 17) + 1) + 1,
   parameter int DEPTH       = 128
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        BRAM_en_i,
   input  logic [3:0]  BRAM_we_i,
   input  logic [31:0] BRAM_addr_i,
   input  logic [31:0] BRAM_din_i,
   output logic [31:0] BRAM_dout_o,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   input  logic [16:0] s_data_i,
   output logic        m_valid_o,
   input  logic        m_ready_i,
   output logic [16:0] m_data_o,
   output logic        mm_start_o,
   input  logic        mm_done_i,
   output logic        busy_o
);

   localparam int S  = ((WIDTH + 1) / 17) + 1;
   localparam int AW = $clog2(DEPTH);

   localparam logic [AW-1:0] LAST_LOAD  = AW'(LOAD_WORDS - 1);
   localparam logic [AW-1:0] LAST_LIMB  = AW'(S - 1);
   localparam logic [AW-1:0] LIMB_COUNT = AW'(S);
   localparam logic [AW-1:0] RES_BASE   = AW'(RESULT_BASE);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   logic [31:0]   mem [DEPTH];

   state_t        state;
   state_t        state_next;
   logic          s_ready_q;
   logic          busy_q;
   logic          start_q;
   logic [AW-1:0] load_cnt;

   logic [AW-1:0] iss_cnt;
   logic [AW-1:0] pop_cnt;
   logic          rd_valid;
   logic [16:0]   rd_data;
   logic          skid_valid;
   logic [16:0]   skid_data;
   logic          out_valid;
   logic [16:0]   out_data;
   logic [31:0]   dout_q;

   logic [AW-1:0] mul_idx;
   logic          mul_in_range;
   logic          host_hs;
   logic          pop;
   logic [1:0]    occ;
   logic          issue;
   logic [AW-1:0] rd_idx;
   logic          unused_addr_bits;

   assign mul_idx          = BRAM_addr_i[AW+1:2];
   assign mul_in_range     = (BRAM_addr_i[31:AW+2] == '0);
   assign unused_addr_bits = ^BRAM_addr_i[1:0];

   // s_ready_q is only ever high in LOAD, so it alone qualifies a host write.
   assign host_hs = s_valid_i && s_ready_q;
   assign pop     = out_valid && m_ready_i;

   // Limbs owned by the read path: one in the memory read stage, one on the
   // output register, one in the skid register. A new read is issued only if
   // after this edge's pop at most two limbs would be in flight, so a limb
   // arriving from memory always finds either the output or the skid free.
   assign occ    = 2'(rd_valid) + 2'(out_valid) + 2'(skid_valid);
   assign issue  = (state == ST_READ) && (iss_cnt != LIMB_COUNT) && ((occ - 2'(pop)) < 2'd2);
   assign rd_idx = RES_BASE + iss_cnt;

   // Memory array: contents are never reset. Host write goes first so that the
   // multiplier's byte writes override it when both hit the same word.
   always_ff @(posedge clock_i) begin
      if (host_hs && !reset_i) begin
         mem[load_cnt] <= {15'b0, s_data_i};
      end
      if (BRAM_en_i && mul_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (BRAM_we_i[b]) begin
               mem[mul_idx][8*b +: 8] <= BRAM_din_i[8*b +: 8];
            end
         end
      end
   end

   // Multiplier read port: read-first, holds when not enabled, zero when the
   // address lies outside the memory.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         dout_q <= '0;
      end else if (BRAM_en_i) begin
         dout_q <= mul_in_range ? mem[mul_idx] : 32'd0;
      end
   end

   // State register with the control outputs registered from the next state,
   // so they line up with the state they describe.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state     <= ST_LOAD;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         start_q   <= 1'b0;
         load_cnt  <= '0;
      end else begin
         state     <= state_next;
         s_ready_q <= (state_next == ST_LOAD);
         busy_q    <= (state_next != ST_LOAD);
         start_q   <= (state_next == ST_START);
         if (host_hs) begin
            load_cnt <= (load_cnt == LAST_LOAD) ? '0 : load_cnt + AW'(1);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_LOAD:  if (host_hs && (load_cnt == LAST_LOAD)) state_next = ST_START;
         ST_START: state_next = ST_WAIT;
         ST_WAIT:  if (mm_done_i) state_next = ST_READ;
         ST_READ:  if (pop && (pop_cnt == LAST_LIMB)) state_next = ST_LOAD;
         default:  state_next = ST_LOAD;
      endcase
   end

   // Result streaming: memory read stage feeding an output register backed by
   // a one-entry skid register. Everything is flushed outside READ.
   always_ff @(posedge clock_i) begin
      if (reset_i || (state != ST_READ)) begin
         iss_cnt    <= '0;
         pop_cnt    <= '0;
         rd_valid   <= 1'b0;
         skid_valid <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         rd_valid <= issue;
         if (issue) begin
            rd_data <= mem[rd_idx][16:0];
            iss_cnt <= iss_cnt + AW'(1);
         end
         if (pop) begin
            pop_cnt <= pop_cnt + AW'(1);
         end
         if (!out_valid || m_ready_i) begin
            if (skid_valid) begin
               out_data  <= skid_data;
               out_valid <= 1'b1;
               if (rd_valid) begin
                  skid_data <= rd_data;
               end else begin
                  skid_valid <= 1'b0;
               end
            end else if (rd_valid) begin
               out_data  <= rd_data;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (rd_valid) begin
            skid_data  <= rd_data;
            skid_valid <= 1'b1;
         end
      end
   end

   assign BRAM_dout_o = dout_q;
   assign s_ready_o   = s_ready_q;
   assign m_valid_o   = out_valid;
   assign m_data_o    = out_data;
   assign mm_start_o  = start_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mm_bram_host_port.sv
// tb_mm_bram_host_port
// Directed bench for mm_bram_host_port at default parameters (S = 16 limbs,
// 49 load words, results at word 49). Inputs are driven and outputs sampled
// just after the falling clock edge.
module tb_mm_bram_host_port;

   localparam int S          = 16;
   localparam int LOAD_WORDS = 49;
   localparam int RES_BASE   = 49;

   logic        clock;
   logic        reset;
   logic        bramEn;
   logic [3:0]  bramWe;
   logic [31:0] bramAddr;
   logic [31:0] bramDin;
   logic [31:0] bramDout;
   logic        sValid;
   logic        sReady;
   logic [16:0] sData;
   logic        mValid;
   logic        mReady;
   logic [16:0] mData;
   logic        mmStart;
   logic        mmDone;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   int hsCount     = 0;
   int startCount  = 0;

   mm_bram_host_port dut (
      .clock_i     (clock),
      .reset_i     (reset),
      .BRAM_en_i   (bramEn),
      .BRAM_we_i   (bramWe),
      .BRAM_addr_i (bramAddr),
      .BRAM_din_i  (bramDin),
      .BRAM_dout_o (bramDout),
      .s_valid_i   (sValid),
      .s_ready_o   (sReady),
      .s_data_i    (sData),
      .m_valid_o   (mValid),
      .m_ready_i   (mReady),
      .m_data_o    (mData),
      .mm_start_o  (mmStart),
      .mm_done_i   (mmDone),
      .busy_o      (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count host handshakes and start-pulse cycles as seen at each rising edge.
   always @(posedge clock) begin
      if (sValid === 1'b1 && sReady === 1'b1) hsCount++;
      if (mmStart === 1'b1) startCount++;
   end

   // Safety net so a stuck run still ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One multiplier-port access: drive for one rising edge, then release enable.
   task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
      bramEn   = en;
      bramWe   = we;
      bramAddr = addr;
      bramDin  = din;
      @(negedge clock);
      bramEn = 1'b0;
      bramWe = 4'h0;
   endtask

   // Stream limbs 0x00001+k for k = 0..48 and confirm the single start pulse.
   task automatic loadOperands(input bit withGaps);
      int hsBase;
      int startBase;
      int gap;
      hsBase    = hsCount;
      startBase = startCount;
      for (int k = 0; k < LOAD_WORDS; k++) begin
         if (withGaps) begin
            gap    = $urandom_range(0, 2);
            sValid = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge clock);
         end
         sValid = 1'b1;
         sData  = 17'(k + 1);
         @(negedge clock);
      end
      sValid = 1'b0;
      checkOutput("mm_start_after_last_load", 32'(mmStart), 32'd1);
      checkOutput("s_ready_low_in_start", 32'(sReady), 32'd0);
      @(negedge clock);
      checkOutput("mm_start_single_cycle", 32'(mmStart), 32'd0);
      checkOutput("busy_in_wait", 32'(busy), 32'd1);
      checkOutput("load_handshakes", 32'(hsCount - hsBase), 32'd49);
      checkOutput("start_pulse_count", 32'(startCount - startBase), 32'd1);
   endtask

   // Pulse done with ready held high and check the exact stream timing.
   task automatic streamAllFromDone();
      mReady = 1'b1;
      mmDone = 1'b1;
      @(negedge clock);
      mmDone = 1'b0;
      checkOutput("valid_after_done_edge", 32'(mValid), 32'd0);
      @(negedge clock);
      checkOutput("valid_one_after_done", 32'(mValid), 32'd0);
      @(negedge clock);
      for (int k = 0; k < S; k++) begin
         checkOutput("stream_valid", 32'(mValid), 32'd1);
         checkOutput("stream_limb", 32'(mData), 32'h1FFFF - 32'(k));
         @(negedge clock);
      end
      checkOutput("stream_end_valid", 32'(mValid), 32'd0);
      checkOutput("stream_end_s_ready", 32'(sReady), 32'd1);
      checkOutput("stream_end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int  idx;
      bit  prevValid;
      bit  prevReady;
      logic [16:0] prevData;
      int  waitCycles;

      reset    = 1'b1;
      bramEn   = 1'b0;
      bramWe   = 4'h0;
      bramAddr = 32'h0;
      bramDin  = 32'h0;
      sValid   = 1'b0;
      sData    = 17'h0;
      mReady   = 1'b0;
      mmDone   = 1'b0;

      // Two reset cycles: every output quiet.
      @(negedge clock);
      @(negedge clock);
      checkOutput("reset_s_ready", 32'(sReady), 32'd0);
      checkOutput("reset_m_valid", 32'(mValid), 32'd0);
      checkOutput("reset_mm_start", 32'(mmStart), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_bram_dout", bramDout, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("s_ready_after_release", 32'(sReady), 32'd1);

      // Load with random gaps, then read every operand word back.
      loadOperands(1'b1);
      for (int k = 0; k < LOAD_WORDS; k++) begin
         applyStimulus(1'b1, 4'h0, 32'(4 * k), 32'h0);
         checkOutput("bram_read_operand", bramDout, 32'(k + 1));
      end

      // Byte enables, read-first, address aliasing and out-of-range accesses.
      applyStimulus(1'b1, 4'hF, 32'h0000_000C, 32'h0001_2345);
      checkOutput("read_first_full_write", bramDout, 32'h0000_0004);
      applyStimulus(1'b1, 4'b0011, 32'h0000_000C, 32'hAABB_CCDD);
      checkOutput("read_first_byte_write", bramDout, 32'h0001_2345);
      applyStimulus(1'b1, 4'h0, 32'h0000_000C, 32'h0);
      checkOutput("byte_enable_merge", bramDout, 32'h0001_CCDD);
      applyStimulus(1'b1, 4'h0, 32'h0000_000E, 32'h0);
      checkOutput("low_addr_bits_ignored", bramDout, 32'h0001_CCDD);
      applyStimulus(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
      checkOutput("out_of_range_write_dout", bramDout, 32'h0);
      applyStimulus(1'b1, 4'h0, 32'h0000_1000, 32'h0);
      checkOutput("out_of_range_read", bramDout, 32'h0);
      applyStimulus(1'b1, 4'h0, 32'h0000_0000, 32'h0);
      checkOutput("alias_word_untouched", bramDout, 32'h0000_0001);
      applyStimulus(1'b0, 4'h0, 32'h0000_000C, 32'h0);
      checkOutput("dout_holds_when_idle", bramDout, 32'h0000_0001);

      // Multiplier deposits its result, then signals done.
      for (int k = 0; k < S; k++) begin
         applyStimulus(1'b1, 4'hF, 32'(4 * (RES_BASE + k)), 32'h1FFFF - 32'(k));
      end
      streamAllFromDone();

      // Done while loading must not start a read.
      mmDone = 1'b1;
      @(negedge clock);
      mmDone = 1'b0;
      checkOutput("done_in_load_busy", 32'(busy), 32'd0);
      checkOutput("done_in_load_s_ready", 32'(sReady), 32'd1);
      @(negedge clock);
      checkOutput("done_in_load_busy_later", 32'(busy), 32'd0);
      checkOutput("done_in_load_m_valid", 32'(mValid), 32'd0);

      // Second round with the result sink toggling ready.
      loadOperands(1'b0);
      mReady = 1'b0;
      mmDone = 1'b1;
      @(negedge clock);
      mmDone    = 1'b0;
      idx       = 0;
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevData  = 17'h0;
      for (int cyc = 0; cyc < 300 && idx < S; cyc++) begin
         if (prevValid && prevReady) begin
            checkOutput("bp_limb", 32'(prevData), 32'h1FFFF - 32'(idx));
            idx++;
         end else if (prevValid) begin
            checkOutput("bp_hold_valid", 32'(mValid), 32'd1);
            checkOutput("bp_hold_data", 32'(mData), 32'(prevData));
         end
         prevValid = (mValid === 1'b1);
         prevData  = mData;
         mReady    = 1'($urandom_range(0, 1));
         prevReady = mReady;
         @(negedge clock);
      end
      checkOutput("bp_limb_count", 32'(idx), 32'd16);
      checkOutput("bp_end_valid", 32'(mValid), 32'd0);
      checkOutput("bp_end_s_ready", 32'(sReady), 32'd1);

      // Third round: reset after five result beats, then a full clean round.
      loadOperands(1'b1);
      mReady = 1'b1;
      mmDone = 1'b1;
      @(negedge clock);
      mmDone     = 1'b0;
      waitCycles = 0;
      while (mValid !== 1'b1 && waitCycles < 10) begin
         @(negedge clock);
         waitCycles++;
      end
      checkOutput("rst_round_first_valid", 32'(mValid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("rst_round_limb", 32'(mData), 32'h1FFFF - 32'(k));
         @(negedge clock);
      end
      reset = 1'b1;
      @(negedge clock);
      checkOutput("mid_read_reset_m_valid", 32'(mValid), 32'd0);
      checkOutput("mid_read_reset_busy", 32'(busy), 32'd0);
      checkOutput("mid_read_reset_s_ready", 32'(sReady), 32'd0);
      checkOutput("mid_read_reset_mm_start", 32'(mmStart), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("after_reset_s_ready", 32'(sReady), 32'd1);
      checkOutput("after_reset_m_valid", 32'(mValid), 32'd0);
      loadOperands(1'b0);
      streamAllFromDone();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
